// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, ALU and write-back encodings plus the packed control word shared by the decoder and control_unit
package ctrl_pkg;
  localparam logic [3:0] OP_NOP     = 4'b0000;
  localparam logic [3:0] OP_STORE   = 4'b0011;
  localparam logic [3:0] OP_ADD     = 4'b0100;
  localparam logic [3:0] OP_INC     = 4'b0101;
  localparam logic [3:0] OP_NEG     = 4'b0110;
  localparam logic [3:0] OP_SUB     = 4'b0111;
  localparam logic [3:0] OP_JUMP    = 4'b1000;
  localparam logic [3:0] OP_BRZ     = 4'b1001;
  localparam logic [3:0] OP_JUMPMEM = 4'b1010;
  localparam logic [3:0] OP_BRN     = 4'b1011;
  localparam logic [3:0] OP_LOAD    = 4'b1110;
  localparam logic [3:0] OP_SVPC    = 4'b1111;
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_NEG  = 3'b011;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;
  typedef struct packed {
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] wb;
    logic       reg_wrt;
    logic       br_zero;
    logic       br_neg;
    logic       jump;
    logic       jump_mem;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode -> ctrl_t decoder (opcode in, ctrl out); undefined or X/Z opcodes give NOP with illegal set
module control_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_NOP: ;
      OP_SVPC: begin ctrl.wb = WB_PC; ctrl.reg_wrt = 1'b1; end
      OP_LOAD: begin ctrl.mem_read = 1'b1; ctrl.wb = WB_MEM; ctrl.reg_wrt = 1'b1; end
      OP_STORE: ctrl.mem_write = 1'b1;
      OP_ADD: begin ctrl.alu_op = ALU_ADD; ctrl.wb = WB_ALU; ctrl.reg_wrt = 1'b1; end
      OP_INC: begin ctrl.alu_op = ALU_ADD; ctrl.alu_src = 1'b1; ctrl.wb = WB_ALU; ctrl.reg_wrt = 1'b1; end
      OP_NEG: begin ctrl.alu_op = ALU_NEG; ctrl.reg_wrt = 1'b1; end
      OP_SUB: begin ctrl.alu_op = ALU_SUB; ctrl.reg_wrt = 1'b1; end
      OP_JUMP: ctrl.jump = 1'b1;
      OP_BRZ: ctrl.br_zero = 1'b1;
      OP_JUMPMEM: begin ctrl.mem_read = 1'b1; ctrl.jump_mem = 1'b1; end
      OP_BRN: ctrl.br_neg = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: registered instruction decoder (clk, rst, en, opcode -> aluOp/mem/wb/regWrt/branch/jump controls + illegal, 1-cycle latency, en=0 holds)
module control_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] opcode,
  output logic [2:0] aluOp,
  output logic       memRead,
  output logic       memWrite,
  output logic       aluSrc,
  output logic [1:0] writeBackControl,
  output logic       regWrt,
  output logic       branchZero,
  output logic       branchNeg,
  output logic       jump,
  output logic       jumpMem,
  output logic       illegal
);
  ctrl_t dec, ctrl_d, ctrl_q;
  control_decode u_dec (.opcode(opcode), .ctrl(dec));
  always_comb ctrl_d = en ? dec : ctrl_q;
  always_ff @(posedge clk) begin
    if (rst) ctrl_q <= '0;
    else ctrl_q <= ctrl_d;
  end
  assign aluOp            = ctrl_q.alu_op;
  assign memRead          = ctrl_q.mem_read;
  assign memWrite         = ctrl_q.mem_write;
  assign aluSrc           = ctrl_q.alu_src;
  assign writeBackControl = ctrl_q.wb;
  assign regWrt           = ctrl_q.reg_wrt;
  assign branchZero       = ctrl_q.br_zero;
  assign branchNeg        = ctrl_q.br_neg;
  assign jump             = ctrl_q.jump;
  assign jumpMem          = ctrl_q.jump_mem;
  assign illegal          = ctrl_q.illegal;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed + random scoreboard bench for control_unit
module tb_control_unit;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic [2:0] aluOp;
  logic memRead, memWrite, aluSrc, regWrt, branchZero, branchNeg, jump, jumpMem, illegal;
  logic [1:0] writeBackControl;
  logic [13:0] obs, cur = '0;
  logic [13:0] sb[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  control_unit dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode),
    .aluOp(aluOp), .memRead(memRead), .memWrite(memWrite), .aluSrc(aluSrc),
    .writeBackControl(writeBackControl), .regWrt(regWrt),
    .branchZero(branchZero), .branchNeg(branchNeg), .jump(jump), .jumpMem(jumpMem),
    .illegal(illegal)
  );
  assign obs = {aluOp, memRead, memWrite, aluSrc, writeBackControl, regWrt,
                branchZero, branchNeg, jump, jumpMem, illegal};
  // row order: aluOp, memRead, memWrite, aluSrc, wb, regWrt, bz, bn, jump, jumpMem, illegal
  function automatic logic [13:0] ref_row(input logic [3:0] op);
    case (op)
      4'b0000: return 14'b000_0_0_0_00_0_0_0_0_0_0;
      4'b1111: return 14'b000_0_0_0_10_1_0_0_0_0_0;
      4'b1110: return 14'b000_1_0_0_01_1_0_0_0_0_0;
      4'b0011: return 14'b000_0_1_0_00_0_0_0_0_0_0;
      4'b0100: return 14'b001_0_0_0_00_1_0_0_0_0_0;
      4'b0101: return 14'b001_0_0_1_00_1_0_0_0_0_0;
      4'b0110: return 14'b011_0_0_0_00_1_0_0_0_0_0;
      4'b0111: return 14'b010_0_0_0_00_1_0_0_0_0_0;
      4'b1000: return 14'b000_0_0_0_00_0_0_0_1_0_0;
      4'b1001: return 14'b000_0_0_0_00_0_1_0_0_0_0;
      4'b1010: return 14'b000_1_0_0_00_0_0_0_0_1_0;
      4'b1011: return 14'b000_0_0_0_00_0_0_1_0_0_0;
      default: return 14'b000_0_0_0_00_0_0_0_0_0_1;
    endcase
  endfunction
  task automatic check(input string tag);
    logic [13:0] exp;
    exp = sb.pop_front();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    total++;
    assert ((32'(branchZero) + 32'(branchNeg) + 32'(jump) + 32'(jumpMem)) <= 1) else begin
      bad++;
      $error("FAIL %s_onehot observed=%b%b%b%b expected=at_most_one", tag, branchZero, branchNeg, jump, jumpMem);
    end
    total++;
    assert (!(memRead && memWrite)) else begin
      bad++;
      $error("FAIL %s_memrw observed=%b%b expected=not_both", tag, memRead, memWrite);
    end
    total++;
    assert (!(regWrt && (memWrite || branchZero || branchNeg || jump || jumpMem))) else begin
      bad++;
      $error("FAIL %s_regwrt observed=%b expected=0", tag, regWrt);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic [3:0] op, input string tag);
    @(negedge clk);
    rst = r;
    en = e;
    opcode = op;
    cur = r ? '0 : (e ? ref_row(op) : cur);
    sb.push_back(cur);
    @(posedge clk);
    #1;
    check(tag);
  endtask
  initial begin
    logic [3:0] sweep[12];
    logic [3:0] ill[4];
    sweep = '{4'b1111, 4'b1110, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
              4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0000};
    ill = '{4'b0001, 4'b0010, 4'b1100, 4'b1101};
    step(1'b1, 1'b1, 4'b0100, "reset0");
    step(1'b1, 1'b1, 4'b0100, "reset1");
    step(1'b0, 1'b1, 4'b0100, "reset_release");
    foreach (sweep[i]) step(1'b0, 1'b1, sweep[i], $sformatf("sweep_%b", sweep[i]));
    foreach (ill[i]) step(1'b0, 1'b1, ill[i], $sformatf("illegal_%b", ill[i]));
    step(1'b0, 1'b1, 4'b0000, "illegal_clear");
    step(1'b0, 1'b1, 4'b0111, "stall_sub");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0011, $sformatf("stall_hold%0d", i));
    step(1'b0, 1'b1, 4'b0011, "stall_release");
    step(1'b0, 1'b1, 4'b1010, "jumpmem");
    step(1'b1, 1'b0, 4'b1010, "reset_over_stall");
    for (int i = 0; i < 1000; i++)
      step($urandom_range(0, 31) == 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "random");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main instruction control decoder for the team's 4-bit-opcode accumulator-less RISC datapath.
- Maps the instruction opcode to ALU, memory, write-back, register-file and branch/jump control signals.
- Outputs are registered: one pipeline stage between instruction fetch/decode and the execute/memory stages.
- Also flags unused opcodes.

Parameters:
- none (opcode and control encodings are fixed constants in the shared package)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  decode enable; 0 = hold all outputs (pipeline stall)
- opcode  input  4  instruction opcode field
- aluOp  output  3  ALU function: 000 PASS, 001 ADD, 010 SUB, 011 NEG (others reserved, never driven)
- memRead  output  1  data memory read
- memWrite  output  1  data memory write
- aluSrc  output  1  ALU B operand: 0 = register rt, 1 = sign-extended immediate
- writeBackControl  output  2  register write-back source: 00 ALU result, 01 memory data, 10 PC-relative value (PC+imm); 11 reserved, never driven
- regWrt  output  1  register file write enable
- branchZero  output  1  conditional branch if Z flag set
- branchNeg  output  1  conditional branch if N flag set
- jump  output  1  unconditional jump to register target
- jumpMem  output  1  jump to target read from memory
- illegal  output  1  opcode is not a defined instruction

Behaviour:
- Reset: when rst=1 at a rising edge, all outputs are cleared to 0, which is the NOP encoding. rst has priority over en.
- Latency: outputs reflect the opcode sampled at the previous rising edge when en=1. This is exactly 1 cycle.
- Stall: when en=0, all outputs hold their values, including illegal.
- Decode table. Fields are listed as aluOp, memRead, memWrite, aluSrc, writeBackControl, regWrt, branchZero, branchNeg, jump, jumpMem. Any field not listed is 0.
  - 0000 NOP: all 0
  - 1111 SVPC: wb=10, regWrt=1
  - 1110 LOAD: memRead=1, wb=01, regWrt=1
  - 0011 STORE: memWrite=1
  - 0100 ADD: aluOp=001, wb=00, regWrt=1
  - 0101 INC: aluOp=001, aluSrc=1, wb=00, regWrt=1
  - 0110 NEG: aluOp=011, regWrt=1
  - 0111 SUB: aluOp=010, regWrt=1
  - 1000 JUMP: jump=1
  - 1001 BRZ: branchZero=1
  - 1010 JUMPMEM: memRead=1, jumpMem=1
  - 1011 BRN: branchNeg=1
- Undefined opcodes 0001, 0010, 1100, 1101 decode exactly as NOP, with illegal=1 (registered alongside the other outputs).
- illegal=0 for every defined opcode.
- Invariants, checked by the verifier every cycle:
  - at most one of branchZero, branchNeg, jump, jumpMem is set
  - memRead and memWrite are never both set
  - regWrt=0 whenever memWrite or any branch/jump bit is set
- X or Z on opcode while en=1: decode as NOP with illegal=1. No X may propagate to the outputs.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams (OP_NOP, OP_SVPC, OP_LOAD, OP_STORE, OP_ADD, OP_INC, OP_NEG, OP_SUB, OP_JUMP, OP_BRZ, OP_JUMPMEM, OP_BRN)
  - ALU codes (ALU_PASS, ALU_ADD, ALU_SUB, ALU_NEG)
  - write-back codes (WB_ALU, WB_MEM, WB_PC)
  - a packed control-word struct covering all output fields
- Sub-module control_decode: purely combinational opcode-to-control-word decoder.
- control_unit: instantiates control_decode, registers its output with reset/enable, and unpacks the register to the ports.

Test Plan:
- Reset: hold rst=1 with opcode=0100 for 2 cycles. All outputs must be 0; illegal=0. Release rst; one cycle later aluOp=001 and regWrt=1.
- Full sweep: apply opcodes 1111, 1110, 0011, 0100, 0101, 0110, 0111, 1000, 1001, 1010, 1011, 0000, one per cycle with en=1. Each cycle's outputs must match the previous opcode's table row. Examples: LOAD gives memRead=1, wb=01, regWrt=1; INC gives aluOp=001, aluSrc=1.
- Illegal opcodes: apply 0001, 0010, 1100, 1101. Each must give all control outputs 0 and illegal=1. Then opcode 0000 must give illegal=0.
- Stall: decode 0111 (aluOp=010, regWrt=1), then set en=0 and apply 0011 for 3 cycles. Outputs must stay at the SUB values. Raise en; the next cycle shows memWrite=1, regWrt=0.
- Reset mid-stream: decode 1010 (memRead=1, jumpMem=1), then assert rst with en=0. Next cycle all outputs must be 0 (reset overrides stall).
- Random opcodes for 1000 cycles with random en: check the invariants and compare against a reference-model table each cycle.
